rr_arbiter_8: RTL and testbench

Round-robin arbiter sharing one 8-way resource among eight requesters. Each cycle it resolves a multi-hot request vector to a single registered one-hot grant plus its 3-bit binary index, holds the grant while the winner keeps requesting, and forces release after a configurable hold limit. It sits in front of the shared resource and drives that resource's select lines directly from its grant outputs.

---
 rtl/rr_arbiter_8_if.sv | 25 ++
 rtl/rr_arbiter_8.sv | 115 +++++++++++
 tb/tb_rr_arbiter_8.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the eight requesters and the round-robin arbiter.
// The arbiter uses the slave modport; the requester side uses the master modport.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a registered one-hot grant, a binary index
// and forced release after MAX_HOLD consecutive grant cycles.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_8_if.slave arb
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_r;
  logic [2:0] ptr_r;
  logic [7:0] cnt_r;
  logic [7:0] grant_r;
  logic [2:0] grant_idx_r;
  logic       grant_valid_r;
  logic       timeout_r;
  logic [2:0] winner_s;

  // First set request bit scanning upward from the pointer, wrapping past 7.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] w;
    logic [2:0] idx;
    logic       found;
    w     = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // Winner of the current request vector relative to the round-robin pointer.
  always_comb begin
    winner_s = rr_pick(arb.req, ptr_r);
  end

  // Arbitration state, hold counter, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      ptr_r         <= 3'd0;
      cnt_r         <= 8'd0;
      grant_r       <= 8'h00;
      grant_idx_r   <= 3'd0;
      grant_valid_r <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_r <= 1'b0;
          if (arb.req != 8'h00) begin
            grant_r       <= 8'd1 << winner_s;
            grant_idx_r   <= winner_s;
            grant_valid_r <= 1'b1;
            ptr_r         <= winner_s + 3'd1;
            cnt_r         <= 8'd0;
            state_r       <= GRANT;
          end else begin
            grant_r       <= 8'h00;
            grant_idx_r   <= 3'd0;
            grant_valid_r <= 1'b0;
            state_r       <= IDLE;
          end
        end
        GRANT: begin
          // A holder dropping its request on the last allowed cycle is a normal release.
          if (!arb.req[grant_idx_r]) begin
            grant_r       <= 8'h00;
            grant_idx_r   <= 3'd0;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
            state_r       <= IDLE;
          end else if (cnt_r == HOLD_LAST) begin
            grant_r       <= 8'h00;
            grant_idx_r   <= 3'd0;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b1;
            state_r       <= IDLE;
          end else begin
            cnt_r     <= cnt_r + 8'd1;
            timeout_r <= 1'b0;
            state_r   <= GRANT;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= 8'h00;
          grant_idx_r   <= 3'd0;
          grant_valid_r <= 1'b0;
          timeout_r     <= 1'b0;
        end
      endcase
    end
  end

  assign arb.grant       = grant_r;
  assign arb.grant_idx   = grant_idx_r;
  assign arb.grant_valid = grant_valid_r;
  assign arb.timeout     = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: three instances (MAX_HOLD 2, 4, 16) share one request
// vector; a cycle model queues expected outputs that are popped after each edge.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  rr_arbiter_8_if if_a ();
  rr_arbiter_8_if if_b ();
  rr_arbiter_8_if if_c ();

  assign if_a.req = req;
  assign if_b.req = req;
  assign if_c.req = req;

  rr_arbiter_8 #(.MAX_HOLD(2))  dut_a (.clk(clk), .rst(rst), .arb(if_a.slave));
  rr_arbiter_8 #(.MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .arb(if_b.slave));
  rr_arbiter_8 #(.MAX_HOLD(16)) dut_c (.clk(clk), .rst(rst), .arb(if_c.slave));

  logic [12:0] obs [3];
  assign obs[0] = {if_a.grant, if_a.grant_idx, if_a.grant_valid, if_a.timeout};
  assign obs[1] = {if_b.grant, if_b.grant_idx, if_b.grant_valid, if_b.timeout};
  assign obs[2] = {if_c.grant, if_c.grant_idx, if_c.grant_valid, if_c.timeout};

  // Reference state: busy flag, pointer, grant cycles held so far, outputs.
  logic        m_busy [3];
  logic [2:0]  m_ptr  [3];
  int unsigned m_held [3];
  logic [7:0]  m_g    [3];
  logic [2:0]  m_gi   [3];
  logic        m_to   [3];
  logic [12:0] exp_q [$];

  function automatic int unsigned limit_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 16);
  endfunction

  task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model_update(input int k, input logic [7:0] r, input logic rs);
    int w;
    if (rs) begin
      m_busy[k] = 1'b0; m_ptr[k] = 3'd0; m_held[k] = 0;
      m_g[k] = 8'h00; m_gi[k] = 3'd0; m_to[k] = 1'b0;
    end else if (!m_busy[k]) begin
      m_to[k] = 1'b0;
      w = -1;
      for (int j = 0; j < 8; j++) begin
        if (w < 0 && r[(int'(m_ptr[k]) + j) % 8]) w = (int'(m_ptr[k]) + j) % 8;
      end
      if (w >= 0) begin
        m_g[k] = 8'h00;
        m_g[k][w] = 1'b1;
        m_gi[k] = 3'(w);
        m_ptr[k] = 3'((w + 1) % 8);
        m_held[k] = 1;
        m_busy[k] = 1'b1;
      end else begin
        m_g[k] = 8'h00; m_gi[k] = 3'd0;
      end
    end else if (!r[m_gi[k]]) begin
      m_busy[k] = 1'b0; m_g[k] = 8'h00; m_gi[k] = 3'd0; m_to[k] = 1'b0;
    end else if (m_held[k] == limit_of(k)) begin
      m_busy[k] = 1'b0; m_g[k] = 8'h00; m_gi[k] = 3'd0; m_to[k] = 1'b1;
    end else begin
      m_held[k] = m_held[k] + 1;
    end
  endtask

  // One clock: drive, let the model predict, then compare all instances after the edge.
  task automatic step(input logic [7:0] r, input logic rs);
    logic [12:0] e;
    req = r;
    rst = rs;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      model_update(k, r, rs);
      exp_q.push_back({m_g[k], m_gi[k], (m_g[k] != 8'h00), m_to[k]});
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      check($sformatf("model_dut%0d", k), obs[k], e);
    end
  endtask

  initial begin
    int          ncycles;
    int          nto;
    logic        prev_v;
    logic [2:0]  order [$];
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = 1'b0; m_ptr[k] = 3'd0; m_held[k] = 0;
      m_g[k] = 8'h00; m_gi[k] = 3'd0; m_to[k] = 1'b0;
    end
    req = 8'h00;
    rst = 1'b1;

    // Reset, then a single requester held three cycles on the MAX_HOLD=16 instance.
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    check("reset_state", obs[2], 13'h0000);
    step(8'h10, 1'b0);
    check("single_grant", {5'h00, if_c.grant}, {5'h00, 8'h10});
    check("single_idx", {10'h000, if_c.grant_idx}, {10'h000, 3'd4});
    nto = 0;
    step(8'h10, 1'b0);
    nto += int'(if_c.timeout);
    step(8'h10, 1'b0);
    nto += int'(if_c.timeout);
    step(8'h00, 1'b0);
    nto += int'(if_c.timeout);
    check("single_release", {5'h00, if_c.grant}, 13'h0000);
    check("single_no_timeout", 13'(nto), 13'd0);

    // Fairness on MAX_HOLD=2: all requesting, grant order 0..7 then 0.
    step(8'h00, 1'b1);
    prev_v = 1'b0;
    for (int i = 0; i < 27; i++) begin
      step(8'hFF, 1'b0);
      if (if_a.grant_valid && !prev_v) order.push_back(if_a.grant_idx);
      prev_v = if_a.grant_valid;
    end
    check("fair_count", 13'(order.size()), 13'd9);
    for (int i = 0; i < order.size() && i < 9; i++) begin
      check($sformatf("fair_order%0d", i), {10'h000, order[i]}, 13'(i % 8));
    end

    // Forced release with no contention on MAX_HOLD=4.
    step(8'h00, 1'b1);
    ncycles = 0;
    nto = 0;
    for (int i = 0; i < 15; i++) begin
      step(8'h04, 1'b0);
      ncycles += int'(if_b.grant_valid);
      nto += int'(if_b.timeout);
    end
    check("force_grant_cycles", 13'(ncycles), 13'd12);
    check("force_timeouts", 13'(nto), 13'd3);

    // Holder drops on the final hold cycle: normal release, next requester served.
    step(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(8'h04, 1'b0);
    step(8'h08, 1'b0);
    check("final_cycle_no_timeout", {12'h000, if_b.timeout}, 13'd0);
    step(8'h08, 1'b0);
    check("final_cycle_next", {5'h00, if_b.grant}, {5'h00, 8'h08});

    // Pointer wrap: after serving 7, index 0 wins over 7.
    step(8'h00, 1'b1);
    step(8'h80, 1'b0);
    check("wrap_first", {5'h00, if_c.grant}, {5'h00, 8'h80});
    step(8'h00, 1'b0);
    step(8'h81, 1'b0);
    check("wrap_second", {5'h00, if_c.grant}, {5'h00, 8'h01});

    // Mid-grant reset with grant on 5 and pointer at 6.
    step(8'h00, 1'b1);
    step(8'h20, 1'b0);
    step(8'h21, 1'b0);
    check("midrst_pre", {5'h00, if_c.grant}, {5'h00, 8'h20});
    step(8'h21, 1'b1);
    check("midrst_zero", obs[2], 13'h0000);
    step(8'h21, 1'b0);
    check("midrst_first", {5'h00, if_c.grant}, {5'h00, 8'h01});

    // Random traffic, model-checked every cycle.
    for (int i = 0; i < 200; i++) begin
      step(8'($urandom) & 8'($urandom), (($urandom_range(0, 49)) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
